// File: rtl/mem_access_unit_pkg.sv
// Shared UIB definitions: access-size encoding, memory-access FSM states and
// the lane helpers used by both the access unit and main memory.
package mem_access_unit_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_BAD  = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return offset[0];
         SZ_WORD: return |offset;
         default: return 1'b1;
      endcase
   endfunction

   // Bring the addressed lane down to bit 0 and clear everything above the access size.
   function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                input logic [1:0]  offset,
                                                input logic [1:0]  size);
      logic [31:0] shifted;
      shifted = word >> {offset, 3'b000};
      case (size)
         SZ_BYTE: return {24'h0, shifted[7:0]};
         SZ_HALF: return {16'h0, shifted[15:0]};
         default: return shifted;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load alignment: lane extract from the bus word, then zero or
// sign extension to XLEN according to the access size.
module load_align
   import mem_access_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      offset,
   input  logic [1:0]      size,
   input  logic            is_unsigned,
   output logic [XLEN-1:0] data
);

   logic [31:0] lane;
   logic        fill;

   assign lane = lane_extract(word[31:0], offset, size);

   always_comb begin
      fill = 1'b0;
      if (!is_unsigned) begin
         case (size)
            SZ_BYTE: fill = lane[7];
            SZ_HALF: fill = lane[15];
            default: fill = lane[31];
         endcase
      end
      data = {XLEN{fill}};
      case (size)
         SZ_BYTE: data[7:0]  = lane[7:0];
         SZ_HALF: data[15:0] = lane[15:0];
         default: data[31:0] = lane;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one core access at a time, runs a single UIB bus
// cycle for aligned accesses and returns a one-cycle response pulse.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_wen,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_err,
   output logic            bus_req,
   output logic            bus_wen,
   output logic [XLEN-1:0] bus_addr,
   output logic [1:0]      bus_mode,
   output logic [XLEN-1:0] bus_wdata,
   input  logic [XLEN-1:0] bus_rdata
);

   localparam int CNT_W = 3;

   state_e           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             accept;
   logic             wen_q, uns_q, err_q;
   logic [1:0]       size_q;
   logic [XLEN-1:0]  addr_q, wdata_q, rdata_q;
   logic [XLEN-1:0]  load_data;

   function automatic logic [XLEN-1:0] replicate(input logic [XLEN-1:0] value,
                                                 input logic [1:0]      size);
      case (size)
         SZ_BYTE: return {(XLEN/8){value[7:0]}};
         SZ_HALF: return {(XLEN/16){value[15:0]}};
         default: return value;
      endcase
   endfunction

   assign accept = req_valid & req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Request fields and the response payload are pure data; outputs are gated by state.
   always_ff @(posedge clk) begin
      if (accept) begin
         wen_q   <= req_wen;
         size_q  <= req_size;
         uns_q   <= req_unsigned;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         err_q   <= misaligned(req_size, req_addr[1:0]);
         rdata_q <= '0;
      end else if (state == ST_WAIT && cnt == '0) begin
         rdata_q <= load_data;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = 1'b0;
      bus_req    = 1'b0;
      bus_wen    = 1'b0;
      bus_addr   = '0;
      bus_mode   = 2'd0;
      bus_wdata  = '0;
      case (state)
         ST_IDLE: begin
            req_ready = ~rst;
            if (req_valid && !rst)
               state_nxt = misaligned(req_size, req_addr[1:0]) ? ST_RESP : ST_BUS;
         end
         ST_BUS: begin
            bus_req   = 1'b1;
            bus_wen   = wen_q;
            bus_addr  = addr_q;
            bus_mode  = size_q;
            bus_wdata = replicate(wdata_q, size_q);
            if (wen_q) begin
               state_nxt = ST_RESP;
            end else begin
               state_nxt = ST_WAIT;
               cnt_nxt   = CNT_W'(RD_LATENCY - 1);
            end
         end
         ST_WAIT: begin
            if (cnt == '0) state_nxt = ST_RESP;
            else           cnt_nxt   = cnt - CNT_W'(1);
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = rdata_q;
            resp_err   = err_q;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   load_align #(.XLEN(XLEN)) u_load_align (
      .word        (bus_rdata),
      .offset      (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (uns_q),
      .data        (load_data)
   );

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: two units (read latency 1 and 3) share one stimulus stream;
// each has its own UIB memory slave and response monitor.
module tb_mem_access_unit;

   localparam int LAT0   = 1;
   localparam int LAT1   = 3;
   localparam int MEM_SZ = 1024;

   typedef struct {
      int          kind;   // 0 error, 1 store, 2 load
      logic [31:0] rdata;
      int          acc;
   } exp_t;

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [1:0]  mode;
      logic [31:0] wdata;
   } bexp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_wen, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready [2];
   logic        resp_valid [2];
   logic        resp_err [2];
   logic        bus_req [2];
   logic        bus_wen [2];
   logic [31:0] resp_rdata [2];
   logic [31:0] bus_addr [2];
   logic [31:0] bus_wdata [2];
   logic [31:0] bus_rdata [2];
   logic [1:0]  bus_mode [2];

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        exp_q [$];
   bexp_t       bus_q [$];
   int          rd_idx [2];
   int          bus_idx [2];
   int          bus_cnt [2];
   int          rd_cnt [2];
   logic [31:0] rd_word [2];
   bit   [7:0]  ref_mem [MEM_SZ];
   bit   [7:0]  bmem [2][MEM_SZ];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_access_unit #(.XLEN(32), .RD_LATENCY(g == 0 ? LAT0 : LAT1)) u_dut (
         .clk          (clk),
         .rst          (rst),
         .req_valid    (req_valid),
         .req_ready    (req_ready[g]),
         .req_wen      (req_wen),
         .req_size     (req_size),
         .req_unsigned (req_unsigned),
         .req_addr     (req_addr),
         .req_wdata    (req_wdata),
         .resp_valid   (resp_valid[g]),
         .resp_rdata   (resp_rdata[g]),
         .resp_err     (resp_err[g]),
         .bus_req      (bus_req[g]),
         .bus_wen      (bus_wen[g]),
         .bus_addr     (bus_addr[g]),
         .bus_mode     (bus_mode[g]),
         .bus_wdata    (bus_wdata[g]),
         .bus_rdata    (bus_rdata[g])
      );
   end

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic fail(input string name, input string msg);
      checks++;
      errors++;
      $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
   endtask

   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit is_bad(input logic [1:0] s, input logic [31:0] a);
      return (s == 2'd3) || ((int'(a[1:0]) % nbytes(s)) != 0);
   endfunction

   function automatic int lat_of(input int i);
      return (i == 0) ? LAT0 : LAT1;
   endfunction

   // Issue one access once both units are idle, and record what each should do.
   task automatic issue(input bit wen, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      exp_t        e;
      bexp_t       b;
      int          n, t, base;
      logic [31:0] v;
      t = 0;
      while (!(req_ready[0] && req_ready[1]) && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 50) fail("ready_wait", "units never became ready");
      req_valid    = 1'b1;
      req_wen      = wen;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      e.acc   = cyc;
      e.rdata = 32'h0;
      if (is_bad(size, addr)) begin
         e.kind = 0;
      end else begin
         n      = nbytes(size);
         base   = int'(addr[9:0]);
         b.wen  = wen;
         b.addr = addr;
         b.mode = size;
         for (int j = 0; j < 4; j++) b.wdata[8*j +: 8] = wdata[8*(j % n) +: 8];
         bus_q.push_back(b);
         if (wen) begin
            e.kind = 1;
            for (int k = 0; k < n; k++) ref_mem[base + k] = wdata[8*k +: 8];
         end else begin
            e.kind = 2;
            v = 32'h0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[base + k];
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            e.rdata = v;
         end
      end
      exp_q.push_back(e);
   endtask

   // Monitor and memory slave for both units, sampled on the falling edge.
   always @(negedge clk) begin
      exp_t        e;
      bexp_t       b;
      int          a, base, want_lat;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            rd_idx[i]    = exp_q.size();
            bus_idx[i]   = bus_q.size();
            bus_cnt[i]   = 0;
            rd_cnt[i]    = 0;
            bus_rdata[i] = 32'h0;
         end else begin
            check($sformatf("u%0d_req_ready", i), 32'(req_ready[i]), 32'(rd_idx[i] >= exp_q.size()));
            if (!resp_valid[i])
               check($sformatf("u%0d_resp_idle", i), resp_rdata[i] | 32'(resp_err[i]), 32'h0);

            if (rd_cnt[i] > 0) begin
               rd_cnt[i]--;
               bus_rdata[i] = (rd_cnt[i] == 0) ? rd_word[i] : $urandom;
            end else begin
               bus_rdata[i] = $urandom;
            end

            if (!bus_req[i]) begin
               check($sformatf("u%0d_bus_idle", i),
                     bus_addr[i] | bus_wdata[i] | {29'h0, bus_wen[i], bus_mode[i]}, 32'h0);
            end else begin
               bus_cnt[i]++;
               if (bus_idx[i] < bus_q.size()) begin
                  b = bus_q[bus_idx[i]];
                  bus_idx[i]++;
                  check($sformatf("u%0d_bus_wen", i), 32'(bus_wen[i]), 32'(b.wen));
                  check($sformatf("u%0d_bus_addr", i), bus_addr[i], b.addr);
                  check($sformatf("u%0d_bus_mode", i), 32'(bus_mode[i]), 32'(b.mode));
                  if (b.wen) check($sformatf("u%0d_bus_wdata", i), bus_wdata[i], b.wdata);
               end else begin
                  fail($sformatf("u%0d_bus_unexpected", i), "bus cycle with no aligned access pending");
               end
               base = int'(bus_addr[i][9:0]) & ~3;
               if (bus_wen[i]) begin
                  for (int k = 0; k < nbytes(bus_mode[i]); k++) begin
                     a = (int'(bus_addr[i][9:0]) + k) % MEM_SZ;
                     bmem[i][a] = bus_wdata[i][8*(a % 4) +: 8];
                  end
               end else begin
                  rd_word[i] = {bmem[i][base+3], bmem[i][base+2], bmem[i][base+1], bmem[i][base]};
                  rd_cnt[i]  = lat_of(i);
               end
            end

            if (resp_valid[i]) begin
               if (rd_idx[i] < exp_q.size()) begin
                  e = exp_q[rd_idx[i]];
                  rd_idx[i]++;
                  want_lat = (e.kind == 0) ? 1 : (e.kind == 1) ? 2 : 2 + lat_of(i);
                  check($sformatf("u%0d_rdata", i), resp_rdata[i], e.rdata);
                  check($sformatf("u%0d_err", i), 32'(resp_err[i]), 32'(e.kind == 0));
                  check($sformatf("u%0d_latency", i), 32'(cyc - e.acc + 1), 32'(want_lat));
                  check($sformatf("u%0d_bus_cycles", i), 32'(bus_cnt[i]), 32'(e.kind != 0));
               end else begin
                  fail($sformatf("u%0d_resp_unexpected", i), "resp_valid with no access pending");
               end
               bus_cnt[i] = 0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [7:0]    v8;
      logic [1:0]  sz;
      logic [31:0] ad;
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_wen      = 1'b0;
      req_size     = 2'd0;
      req_unsigned = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      for (int k = 0; k < MEM_SZ; k++) begin
         v8 = 8'($urandom);
         ref_mem[k] = v8;
         bmem[0][k] = v8;
         bmem[1][k] = v8;
      end

      #2;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("u%0d_rst_ready", i), 32'(req_ready[i]), 32'h0);
         check($sformatf("u%0d_rst_resp", i), 32'(resp_valid[i]) | resp_rdata[i] | 32'(resp_err[i]), 32'h0);
         check($sformatf("u%0d_rst_bus", i), 32'(bus_req[i]) | bus_addr[i] | bus_wdata[i], 32'h0);
      end
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) check($sformatf("u%0d_ready_after_rst", i), 32'(req_ready[i]), 32'h1);

      issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      issue(1'b1, 2'd0, 1'b0, 32'h203, 32'h0000_0080);
      issue(1'b0, 2'd0, 1'b0, 32'h203, 32'h0);
      issue(1'b0, 2'd0, 1'b1, 32'h203, 32'h0);
      issue(1'b0, 2'd1, 1'b0, 32'h101, 32'h0);
      issue(1'b0, 2'd3, 1'b0, 32'h000, 32'h0);
      issue(1'b1, 2'd1, 1'b0, 32'h302, 32'h0000_9ABC);
      issue(1'b0, 2'd1, 1'b0, 32'h302, 32'h0);
      issue(1'b0, 2'd1, 1'b1, 32'h302, 32'h0);

      // Abort a load while both units sit in WAIT.
      issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("u%0d_abort_resp", i), 32'(resp_valid[i]) | resp_rdata[i] | 32'(resp_err[i]), 32'h0);
         check($sformatf("u%0d_abort_bus", i), 32'(bus_req[i]) | bus_addr[i] | bus_wdata[i], 32'h0);
         check($sformatf("u%0d_abort_ready", i), 32'(req_ready[i]), 32'h0);
      end
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b0;
      issue(1'b1, 2'd2, 1'b0, 32'h104, 32'h1234_5678);
      issue(1'b0, 2'd2, 1'b0, 32'h104, 32'h0);

      for (int t = 0; t < 250; t++) begin
         sz = 2'($urandom_range(0, 3));
         ad = 32'($urandom_range(0, MEM_SZ - 1));
         if ($urandom_range(0, 3) != 0 && sz != 2'd3) ad = ad & ~32'(nbytes(sz) - 1);
         issue(1'($urandom), sz, 1'($urandom), ad, $urandom);
      end

      repeat (20) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("u%0d_drain_resp", i), 32'(rd_idx[i]), 32'(exp_q.size()));
         check($sformatf("u%0d_drain_bus", i), 32'(bus_idx[i]), 32'(bus_q.size()));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
